// File: rtl/instr_fetch_cached.sv
// Instruction fetch stage with a direct-mapped, line-refilled instruction cache.
// Hits are resolved combinationally; misses block in MISS until the line arrives.
module instr_fetch_cached #(
  parameter int              ADDR_W     = 16,
  parameter int              INSTR_W    = 16,
  parameter int              LINE_WORDS = 4,
  parameter int              NUM_LINES  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             branch_target,
  input  logic                          PC_src,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ready,
  input  logic [LINE_WORDS*INSTR_W-1:0] mem_line,
  output logic [INSTR_W-1:0]            instr_out,
  output logic                          instr_valid,
  output logic [ADDR_W-1:0]             pc_out,
  output logic [ADDR_W-1:0]             adder_out,
  output logic [15:0]                   miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [0:0] {RUN = 1'b0, MISS = 1'b1} state_t;

  state_t                  state_r, state_n;
  logic [ADDR_W-1:0]       pc_r, pc_n;
  logic                    pend_valid_r, pend_valid_n;
  logic [ADDR_W-1:0]       pend_target_r, pend_target_n;
  logic [15:0]             miss_count_r, miss_count_n;
  logic                    mem_req_r, mem_req_n;
  logic [ADDR_W-1:0]       mem_addr_r, mem_addr_n;
  logic [NUM_LINES-1:0]    valid_r, valid_n;
  logic                    fill_s;

  logic [TAG_W-1:0]              tag_ram  [NUM_LINES];
  logic [LINE_WORDS*INSTR_W-1:0] data_ram [NUM_LINES];

  logic [OFF_W-1:0]        off_s;
  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic                    hit_s;
  logic [ADDR_W-1:0]       pc_inc_s;
  logic [ADDR_W-1:0]       line_addr_s;
  logic [LINE_WORDS*INSTR_W-1:0] line_s;
  logic [INSTR_W-1:0]      words_s [LINE_WORDS];

  assign off_s       = pc_r[OFF_W-1:0];
  assign idx_s       = pc_r[OFF_W +: IDX_W];
  assign tag_s       = pc_r[ADDR_W-1 -: TAG_W];
  assign hit_s       = valid_r[idx_s] && (tag_ram[idx_s] == tag_s);
  assign pc_inc_s    = pc_r + ADDR_W'(1);
  assign line_addr_s = {tag_s, idx_s, {OFF_W{1'b0}}};
  assign line_s      = data_ram[idx_s];

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
    assign words_s[g] = line_s[g*INSTR_W +: INSTR_W];
  end

  assign instr_out   = words_s[off_s];
  assign instr_valid = (state_r == RUN) && hit_s;
  assign pc_out      = pc_r;
  assign adder_out   = pc_inc_s;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign miss_count  = miss_count_r;

  // Next-state and next-PC selection for the RUN/MISS controller.
  always_comb begin
    state_n       = state_r;
    pc_n          = pc_r;
    pend_valid_n  = pend_valid_r;
    pend_target_n = pend_target_r;
    miss_count_n  = miss_count_r;
    mem_req_n     = mem_req_r;
    mem_addr_n    = mem_addr_r;
    fill_s        = 1'b0;
    case (state_r)
      RUN: begin
        if (stall) begin
          pc_n = pc_r;
        end else if (PC_src) begin
          pc_n = branch_target;  // also cancels a wrong-path miss
        end else if (hit_s) begin
          pc_n = pc_inc_s;
        end else begin
          state_n    = MISS;
          mem_req_n  = 1'b1;
          mem_addr_n = line_addr_s;
        end
      end
      MISS: begin
        if (mem_ready) begin
          fill_s       = 1'b1;
          state_n      = RUN;
          mem_req_n    = 1'b0;
          mem_addr_n   = '0;
          pend_valid_n = 1'b0;
          if (miss_count_r != 16'hFFFF) begin
            miss_count_n = miss_count_r + 16'd1;
          end else begin
            miss_count_n = miss_count_r;
          end
          if (PC_src && !stall) begin
            pc_n = branch_target;
          end else if (pend_valid_r) begin
            pc_n = pend_target_r;
          end else begin
            pc_n = pc_r;
          end
        end else if (PC_src && !stall) begin
          pend_valid_n  = 1'b1;
          pend_target_n = branch_target;
        end else begin
          pend_valid_n = pend_valid_r;
        end
      end
      default: begin
        state_n   = RUN;
        mem_req_n = 1'b0;
      end
    endcase
    // flush wins over a same-cycle refill so that line stays invalid
    valid_n = flush ? '0 : (fill_s ? (valid_r | (NUM_LINES'(1) << idx_s)) : valid_r);
  end

  // Controller state, PC, pending redirect, counters and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      pc_r          <= RESET_PC;
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
      miss_count_r  <= 16'd0;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= '0;
      valid_r       <= '0;
    end else begin
      state_r       <= state_n;
      pc_r          <= pc_n;
      pend_valid_r  <= pend_valid_n;
      pend_target_r <= pend_target_n;
      miss_count_r  <= miss_count_n;
      mem_req_r     <= mem_req_n;
      mem_addr_r    <= mem_addr_n;
      valid_r       <= valid_n;
    end
  end

  // Tag and data arrays; contents are qualified by valid_r so need no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_ram[idx_s]  <= tag_s;
      data_ram[idx_s] <= mem_line;
    end
  end

endmodule

// File: tb/tb_instr_fetch_cached.sv
// Directed, table-driven bench for instr_fetch_cached with default parameters.
module tb_instr_fetch_cached;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] branch_target;
  logic        PC_src, stall, flush, mem_ready;
  logic [63:0] mem_line;
  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr_out, pc_out, adder_out, miss_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_cached dut (
    .clk(clk), .rst(rst), .branch_target(branch_target), .PC_src(PC_src),
    .stall(stall), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_line(mem_line), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_out(pc_out), .adder_out(adder_out),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        pc_src;
    logic [15:0] bt;
    logic [15:0] exp_pc;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [63:0] line_at(input logic [15:0] base);
    logic [63:0] l;
    for (int w = 0; w < 4; w++) l[w*16 +: 16] = word_at(base + 16'(w));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expects the DUT in MISS for base; answers after 3 cycles.
  task automatic refill(input logic [15:0] base);
    chk("refill_req", {31'd0, mem_req}, 32'd1);
    chk("refill_addr", {16'd0, mem_addr}, {16'd0, base});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("refill_req_held", {31'd0, mem_req}, 32'd1);
      chk("refill_addr_held", {16'd0, mem_addr}, {16'd0, base});
    end
    mem_ready = 1'b1;
    mem_line  = line_at(base);
    settle();
    tick();
    mem_ready = 1'b0;
    settle();
    chk("refill_done_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic redirect(input logic [15:0] t);
    PC_src = 1'b1;
    branch_target = t;
    settle();
    tick();
    PC_src = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; branch_target = 16'h0000; PC_src = 1'b0; stall = 1'b0;
    flush = 1'b0; mem_ready = 1'b0; mem_line = 64'd0;

    vecs[0] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0000};
    vecs[1] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0001};
    vecs[2] = '{stall: 1'b1, pc_src: 1'b1, bt: 16'h0000, exp_pc: 16'h0002};
    vecs[3] = '{stall: 1'b1, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0002};
    vecs[4] = '{stall: 1'b0, pc_src: 1'b1, bt: 16'h0000, exp_pc: 16'h0002};
    vecs[5] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0000};
    vecs[6] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0001};
    vecs[7] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0002};
    vecs[8] = '{stall: 1'b0, pc_src: 1'b1, bt: 16'h0002, exp_pc: 16'h0003};
    vecs[9] = '{stall: 1'b0, pc_src: 1'b0, bt: 16'h0000, exp_pc: 16'h0002};

    // reset state
    tick();
    chk("rst_pc", {16'd0, pc_out}, 32'h0000);
    chk("rst_adder", {16'd0, adder_out}, 32'h0001);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", {16'd0, miss_count}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("cold_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    refill(16'h0000);
    chk("count1", {16'd0, miss_count}, 32'd1);

    // sequential hits 0..3, then miss on next line
    for (int p = 0; p < 4; p++) begin
      chk("seq_pc", {16'd0, pc_out}, p);
      chk("seq_valid", {31'd0, instr_valid}, 32'd1);
      chk("seq_instr", {16'd0, instr_out}, {16'd0, word_at(16'(p))});
      tick();
    end
    chk("pc4_pc", {16'd0, pc_out}, 32'h0004);
    chk("pc4_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    refill(16'h0004);
    chk("count2", {16'd0, miss_count}, 32'd2);
    chk("pc4_hit", {31'd0, instr_valid}, 32'd1);

    redirect(16'h0000);
    for (int i = 0; i < 10; i++) begin
      stall = vecs[i].stall;
      PC_src = vecs[i].pc_src;
      branch_target = vecs[i].bt;
      settle();
      chk("vec_pc", {16'd0, pc_out}, {16'd0, vecs[i].exp_pc});
      chk("vec_valid", {31'd0, instr_valid}, 32'd1);
      chk("vec_instr", {16'd0, instr_out}, {16'd0, word_at(vecs[i].exp_pc)});
      chk("vec_adder", {16'd0, adder_out}, {16'd0, vecs[i].exp_pc + 16'd1});
      tick();
    end
    stall = 1'b0; PC_src = 1'b0;
    settle();
    chk("vec_end_pc", {16'd0, pc_out}, 32'h0003);

    // branch latched while refilling; last target wins after refill
    redirect(16'h0010);
    chk("m38_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    for (int c = 1; c <= 5; c++) begin
      PC_src = (c == 2);
      branch_target = (c == 2) ? 16'h0040 : 16'h1234;
      settle();
      chk("m38_req", {31'd0, mem_req}, 32'd1);
      chk("m38_addr", {16'd0, mem_addr}, 32'h0010);
      chk("m38_pc", {16'd0, pc_out}, 32'h0010);
      chk("m38_ivalid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    PC_src = 1'b0;
    mem_ready = 1'b1;
    mem_line = line_at(16'h0010);
    settle();
    tick();
    mem_ready = 1'b0;
    settle();
    chk("m38_newpc", {16'd0, pc_out}, 32'h0040);
    chk("count3", {16'd0, miss_count}, 32'd3);
    tick();
    refill(16'h0040);
    chk("count4", {16'd0, miss_count}, 32'd4);
    chk("m38_hit_instr", {16'd0, instr_out}, {16'd0, word_at(16'h0040)});

    // wrong-path miss cancelled by same-cycle redirect
    redirect(16'h0080);
    chk("m39_miss", {31'd0, instr_valid}, 32'd0);
    redirect(16'h0041);
    chk("m39_pc", {16'd0, pc_out}, 32'h0041);
    chk("m39_req", {31'd0, mem_req}, 32'd0);
    chk("m39_count", {16'd0, miss_count}, 32'd4);
    chk("m39_instr", {16'd0, instr_out}, {16'd0, word_at(16'h0041)});

    // flush, then flush coincident with refill completion
    flush = 1'b1; stall = 1'b1;
    settle();
    tick();
    flush = 1'b0;
    settle();
    chk("fl_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl_pc", {16'd0, pc_out}, 32'h0041);
    stall = 1'b0;
    tick();
    chk("fl_req", {31'd0, mem_req}, 32'd1);
    chk("fl_addr", {16'd0, mem_addr}, 32'h0040);
    mem_ready = 1'b1; flush = 1'b1; mem_line = line_at(16'h0040);
    settle();
    tick();
    mem_ready = 1'b0; flush = 1'b0;
    settle();
    chk("fl_fill_count", {16'd0, miss_count}, 32'd5);
    chk("fl_fill_invalid", {31'd0, instr_valid}, 32'd0);
    tick();
    refill(16'h0040);
    chk("count6", {16'd0, miss_count}, 32'd6);
    chk("fl_rehit", {31'd0, instr_valid}, 32'd1);

    // PC wrap at the top of the address space
    redirect(16'hFFFF);
    chk("wrap_adder_miss", {16'd0, adder_out}, 32'h0000);
    tick();
    refill(16'hFFFC);
    chk("count7", {16'd0, miss_count}, 32'd7);
    chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
    chk("wrap_instr", {16'd0, instr_out}, {16'd0, word_at(16'hFFFF)});
    chk("wrap_adder", {16'd0, adder_out}, 32'h0000);
    tick();
    chk("wrap_pc", {16'd0, pc_out}, 32'h0000);
    tick();
    chk("abort_req_before", {31'd0, mem_req}, 32'd1);

    // async reset mid-refill, then stale mem_ready ignored
    rst = 1'b1;
    settle();
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_pc", {16'd0, pc_out}, 32'h0000);
    chk("abort_count", {16'd0, miss_count}, 32'd0);
    mem_ready = 1'b1; stall = 1'b1; mem_line = line_at(16'h0000);
    tick();
    rst = 1'b0;
    tick();
    mem_ready = 1'b0;
    settle();
    chk("stale_count", {16'd0, miss_count}, 32'd0);
    chk("stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_req", {31'd0, mem_req}, 32'd0);
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_cached.md
INSTR_FETCH_CACHED -- requirements
Module: instr_fetch_cached

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning PC / word-address width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning instruction width in bits.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, meaning instructions per cache line (power of 2, >=2).
REQ-004 The block SHALL have parameter NUM_LINES, default 8, meaning direct-mapped cache lines (power of 2, >=2).
REQ-005 The block SHALL have parameter RESET_PC, default 0, meaning PC value after reset.

Interface
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port branch_target, input, ADDR_W bits: redirect address.
REQ-009 The block SHALL have port PC_src, input, 1 bit: select branch_target as next PC.
REQ-010 The block SHALL have port stall, input, 1 bit: hold PC and outputs.
REQ-011 The block SHALL have port flush, input, 1 bit: invalidate all cache lines.
REQ-012 The block SHALL have port mem_req, output, 1 bit: line refill request.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W bits: line-aligned refill address.
REQ-014 The block SHALL have port mem_ready, input, 1 bit: mem_line valid and request accepted.
REQ-015 The block SHALL have port mem_line, input, LINE_WORDS*INSTR_W bits: refill data, word 0 in LSBs.
REQ-016 The block SHALL have port instr_out, output, INSTR_W bits: fetched instruction.
REQ-017 The block SHALL have port instr_valid, output, 1 bit: instr_out/pc_out valid (hit).
REQ-018 The block SHALL have port pc_out, output, ADDR_W bits: current PC.
REQ-019 The block SHALL have port adder_out, output, ADDR_W bits: pc_out+1, modulo 2^ADDR_W.
REQ-020 The block SHALL have port miss_count, output, 16 bits: completed refills, saturating at 0xFFFF.

Function
REQ-021 PC SHALL be word-addressed; address split offset = low log2(LINE_WORDS) bits, index = next log2(NUM_LINES) bits, tag = remainder.
REQ-022 Hit SHALL be computed combinationally: valid[index] && tag_ram[index]==tag; instr_out = selected word of data_ram[index].
REQ-023 FSM states SHALL be RUN and MISS; in RUN, instr_valid = hit; in MISS, instr_valid = 0.
REQ-024 In RUN with !stall and (hit or PC_src), PC SHALL load PC_src ? branch_target : adder_out at the next edge.
REQ-025 In RUN with miss, !stall and !PC_src, the FSM SHALL go to MISS; PC is held.
REQ-026 A miss with PC_src=1 SHALL redirect without refill, cancelling the wrong-path miss.
REQ-027 In MISS, mem_req SHALL be 1 and mem_addr = {tag,index,0}; both are held stable until mem_ready.
REQ-028 On mem_ready in MISS, the block SHALL write the line, set valid and tag, increment miss_count, and return to RUN; the next cycle hits.
REQ-029 PC_src=1 while in MISS SHALL latch branch_target into a pending register, with the last one winning; on refill completion PC loads the pending target, not the held PC.
REQ-030 stall SHALL have priority over PC_src in RUN; with stall=1, PC, FSM state and pending are unchanged, but a MISS refill still completes.
REQ-031 flush SHALL clear all valid bits at the next edge; flush coincident with refill completion leaves that line invalid; in MISS, the FSM and mem_req are unaffected.
REQ-032 PC increment SHALL wrap 2^ADDR_W-1 -> 0.
REQ-033 mem_ready outside MISS SHALL be ignored.

Reset
REQ-034 While rst=1, the block SHALL hold pc_out=RESET_PC, adder_out=RESET_PC+1, FSM=RUN, all valid bits=0, pending cleared, miss_count=0, mem_req=0, mem_addr=0 and instr_valid=0.
REQ-035 Reset asserted mid-refill SHALL abort the refill immediately; a mem_ready arriving after reset is ignored.
REQ-036 Tag and data RAM contents need not be reset.

Verification
REQ-037 Cold start, defaults, mem_ready 3 cycles after mem_req -> mem_addr=0x0000; then pc 0..3 hit on consecutive cycles; at pc=4 mem_req with mem_addr=0x0004; miss_count=2 after the second refill.
REQ-038 Miss at pc=0x0010 with mem_ready held low 5 cycles, PC_src=1 and branch_target=0x0040 in cycle 2 -> mem_addr stays 0x0010; after refill pc_out=0x0040 and a miss for 0x0040 is issued.
REQ-039 Miss with PC_src=1 in the same cycle as the miss in RUN -> no mem_req; next pc_out=branch_target.
REQ-040 stall=1 and PC_src=1 on a hit at pc=0x0002 -> pc_out stays 0x0002 and instr_out stable while stalled.
REQ-041 Warm cache, flush pulse -> next fetch at the same pc misses; miss_count increments by 1.
REQ-042 pc=0xFFFF hit -> adder_out=0x0000 and next pc_out=0x0000; rst asserted mid-MISS -> mem_req=0 asynchronously and pc_out=RESET_PC.
